// File: rtl/lagd_fifo_reader_pkg.sv
// lagd_fifo_pkg: shared reader state encoding and burst counter type
package lagd_fifo_pkg;
  typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_e;
  localparam int unsigned BURST_W = 8;
  typedef logic [BURST_W-1:0] burst_t;
endpackage

// File: rtl/lagd_fifo_reader_if.sv
// lagd_fifo_reader_if: downstream valid/ready stream (data, valid from master; ready from slave)
interface lagd_fifo_reader_if #(parameter int unsigned DATA_WIDTH = 32) ();
  logic [DATA_WIDTH-1:0] data;
  logic valid;
  logic ready;
  modport master(output data, valid, input ready);
  modport slave(input data, valid, output ready);
endinterface

// File: rtl/lagd_fifo_reader_out_reg.sv
// lagd_fifo_out_reg: single-entry valid/ready output register; ports clk_i, rst_ni, clr_i, load_i, data_i, ready_i -> valid_o, data_o, can_accept_o
module lagd_fifo_out_reg #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clr_i,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  ready_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  can_accept_o
);
  logic                  valid_q;
  logic [DATA_WIDTH-1:0] data_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= clr_i ? 1'b0 : load_i | (valid_q & ~ready_i);
      if (load_i) data_q <= data_i;
    end
  assign valid_o      = valid_q;
  assign data_o       = data_q;
  assign can_accept_o = ~valid_q | ready_i;
endmodule

// File: rtl/lagd_fifo_reader.sv
// lagd_fifo_reader: drains burst_len_i FIFO entries to a valid/ready stream; ports: start/flush/burst_len control, busy/done/dropped_cnt status, FIFO pop side, out stream interface
module lagd_fifo_reader
  import lagd_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned BURST_WIDTH = 8,
  parameter bit          DROP_NONE   = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   start_i,
  input  logic [BURST_WIDTH-1:0] burst_len_i,
  output logic                   busy_o,
  output logic                   done_o,
  input  logic                   fifo_empty_i,
  input  logic [DATA_WIDTH-1:0]  fifo_data_i,
  input  logic                   fifo_none_i,
  output logic                   fifo_pop_o,
  output logic [BURST_WIDTH-1:0] dropped_cnt_o,
  lagd_fifo_reader_if.master     out
);
  state_e                 state_q;
  logic [BURST_WIDTH-1:0] rem_q, dropped_q;
  logic                   busy_q, done_q, can_accept, drop, fwd;
  assign fifo_pop_o = (state_q == DRAIN) & (rem_q != '0) & ~fifo_empty_i & can_accept & ~flush_i;
  assign drop       = fifo_pop_o & fifo_none_i & DROP_NONE;
  assign fwd        = fifo_pop_o & ~drop;
  lagd_fifo_out_reg #(.DATA_WIDTH(DATA_WIDTH)) u_out (
    .clk_i, .rst_ni, .clr_i(flush_i), .load_i(fwd), .data_i(fifo_data_i),
    .ready_i(out.ready), .valid_o(out.valid), .data_o(out.data), .can_accept_o(can_accept)
  );
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      dropped_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else if (flush_i) begin
      state_q <= IDLE;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          rem_q     <= burst_len_i;
          dropped_q <= '0;
          state_q   <= (burst_len_i != '0) ? DRAIN : DONE;
          busy_q    <= burst_len_i != '0;
          done_q    <= burst_len_i == '0;
        end
        DRAIN: begin
          if (fifo_pop_o) rem_q <= rem_q - 1'b1;
          if (drop && !(&dropped_q)) dropped_q <= dropped_q + 1'b1;
          // finish only once the last forwarded beat has left the output register
          if (rem_q == '0 && !out.valid) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign dropped_cnt_o = dropped_q;
endmodule

// File: tb/tb_lagd_fifo_reader.sv
// tb_lagd_fifo_reader: directed bursts with a scoreboard-checked output stream
module tb_lagd_fifo_reader;
  import lagd_fifo_pkg::*;
  logic        clk_i = 1'b0, rst_ni = 1'b0, flush_i = 1'b0, start_i = 1'b0;
  burst_t      burst_len_i = '0, dropped_cnt_o;
  logic        busy_o, done_o, fifo_empty_i, fifo_none_i, fifo_pop_o;
  logic [31:0] fifo_data_i;
  logic [32:0] mem [16];
  int          rd = 0, wr = 0, pops = 0, tests = 0, fails = 0;
  logic [31:0] exp_q[$];
  lagd_fifo_reader_if #(.DATA_WIDTH(32)) dn ();
  lagd_fifo_reader #(.DATA_WIDTH(32), .BURST_WIDTH(8), .DROP_NONE(1'b1)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .start_i(start_i),
    .burst_len_i(burst_len_i), .busy_o(busy_o), .done_o(done_o),
    .fifo_empty_i(fifo_empty_i), .fifo_data_i(fifo_data_i), .fifo_none_i(fifo_none_i),
    .fifo_pop_o(fifo_pop_o), .dropped_cnt_o(dropped_cnt_o), .out(dn)
  );
  always #5 clk_i = ~clk_i;
  assign fifo_empty_i = (rd == wr);
  assign fifo_data_i  = mem[rd[3:0]][31:0];
  assign fifo_none_i  = mem[rd[3:0]][32];
  always @(posedge clk_i)
    if (fifo_pop_o) begin
      rd   <= rd + 1;
      pops <= pops + 1;
    end
  always @(negedge clk_i)
    if (rst_ni && dn.valid && dn.ready) begin : mon
      logic [31:0] e;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL beat: got unexpected data %h, required no beat", dn.data);
      end else begin
        e = exp_q.pop_front();
        if (dn.data !== e) begin
          fails++;
          $display("FAIL beat: got %h, required %h", dn.data, e);
        end
      end
    end
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask
  task automatic push(input logic [31:0] d, input logic none, input logic expect_out);
    mem[wr[3:0]] = {none, d};
    wr++;
    if (expect_out) exp_q.push_back(d);
  endtask
  task automatic start(input burst_t len);
    start_i     = 1'b1;
    burst_len_i = len;
    tick();
    start_i = 1'b0;
  endtask
  task automatic wait_done(input string name);
    bit seen = 0;
    for (int n = 0; n < 200 && !seen; n++) begin
      tick();
      seen = done_o;
    end
    chk({name, "_done_seen"}, {31'd0, seen}, 32'd1);
    tick();
    chk({name, "_done_width"}, {31'd0, done_o}, 32'd0);
  endtask
  initial begin
    int p0;
    dn.ready = 1'b0;
    repeat (2) tick();
    chk("rst_valid", {31'd0, dn.valid}, 0);
    chk("rst_data", dn.data, 0);
    chk("rst_busy", {31'd0, busy_o}, 0);
    chk("rst_done", {31'd0, done_o}, 0);
    chk("rst_dropped", {24'd0, dropped_cnt_o}, 0);
    chk("rst_pop", {31'd0, fifo_pop_o}, 0);
    rst_ni = 1'b1;
    tick();
    // back-to-back burst
    push(32'hA, 0, 1); push(32'hB, 0, 1); push(32'hC, 0, 1);
    dn.ready = 1'b1;
    p0 = pops;
    start(3);
    chk("t1_busy", {31'd0, busy_o}, 1);
    for (int i = 0; i < 3; i++) begin
      chk("t1_pop_run", {31'd0, fifo_pop_o}, 1);
      tick();
    end
    chk("t1_pop_end", {31'd0, fifo_pop_o}, 0);
    wait_done("t1");
    chk("t1_pops", pops - p0, 3);
    chk("t1_dropped", {24'd0, dropped_cnt_o}, 0);
    // downstream stall
    push(32'hA, 0, 1); push(32'hB, 0, 1); push(32'hC, 0, 1);
    dn.ready = 1'b0;
    p0 = pops;
    start(3);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("t2_hold_valid", {31'd0, dn.valid}, 1);
      chk("t2_hold_data", dn.data, 32'hA);
      chk("t2_hold_pop", {31'd0, fifo_pop_o}, 0);
      tick();
    end
    dn.ready = 1'b1;
    wait_done("t2");
    chk("t2_pops", pops - p0, 3);
    // none-flagged entry discarded
    push(32'h1, 0, 1); push(32'h2, 1, 0); push(32'h3, 0, 1);
    p0 = pops;
    start(3);
    wait_done("t3");
    chk("t3_dropped", {24'd0, dropped_cnt_o}, 1);
    chk("t3_pops", pops - p0, 3);
    // zero-length burst
    p0 = pops;
    start(0);
    chk("t4_done", {31'd0, done_o}, 1);
    chk("t4_busy", {31'd0, busy_o}, 0);
    chk("t4_dropped_clr", {24'd0, dropped_cnt_o}, 0);
    tick();
    chk("t4_done_off", {31'd0, done_o}, 0);
    chk("t4_busy_off", {31'd0, busy_o}, 0);
    chk("t4_pops", pops - p0, 0);
    // FIFO runs dry mid-burst
    push(32'h21, 0, 1); push(32'h22, 0, 1);
    p0 = pops;
    start(5);
    repeat (8) tick();
    chk("t5_busy", {31'd0, busy_o}, 1);
    chk("t5_pops_part", pops - p0, 2);
    chk("t5_done_stall", {31'd0, done_o}, 0);
    push(32'h23, 0, 1); push(32'h24, 0, 1); push(32'h25, 0, 1);
    wait_done("t5");
    chk("t5_pops", pops - p0, 5);
    // flush with a beat pending
    push(32'h51, 0, 1); push(32'h52, 0, 1); push(32'h53, 0, 1); push(32'h54, 0, 1);
    dn.ready = 1'b0;
    p0 = pops;
    start(4);
    tick();
    chk("t6_valid_pre", {31'd0, dn.valid}, 1);
    flush_i  = 1'b1;
    dn.ready = 1'b1;
    #1;
    chk("t6_pop_flush", {31'd0, fifo_pop_o}, 0);
    tick();
    flush_i = 1'b0;
    chk("t6_valid_post", {31'd0, dn.valid}, 0);
    chk("t6_busy_post", {31'd0, busy_o}, 0);
    chk("t6_pops_flush", pops - p0, 1);
    start(3);
    chk("t6_restart_busy", {31'd0, busy_o}, 1);
    wait_done("t6");
    chk("t6_pops", pops - p0, 4);
    chk("exp_q_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
